log_capture_sequencer: RTL and testbench

//  Sequences one capture of the block-RAM logger. It replaces free-running write enables with an armed,

---
 rtl/log_capture_sequencer_pkg.sv | 38 +++
 rtl/log_capture_sequencer_tick_down_counter.sv | 36 +++
 rtl/log_capture_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_log_capture_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_capture_sequencer_pkg.sv
// Shared definitions for the block-RAM capture sequencer: state codes,
// trigger-mode codes and the trigger evaluation helper. The state and
// trigger codes are also what reg_file decodes on readback.
package log_capture_sequencer_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned TRIG_W  = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE    = 3'd0,
      ST_ARM     = 3'd1,
      ST_DELAY   = 3'd2,
      ST_CAPTURE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   typedef enum logic [TRIG_W-1:0] {
      TRIG_IMM = 2'b00,
      TRIG_I   = 2'b01,
      TRIG_Q   = 2'b10,
      TRIG_IQ  = 2'b11
   } trig_mode_e;

   // Trigger condition for a given mode on the current sync-done levels.
   function automatic logic trig_hit(input logic [TRIG_W-1:0] mode,
                                     input logic              sync_i,
                                     input logic              sync_q);
      logic hit;
      case (mode)
         TRIG_IMM: hit = 1'b1;
         TRIG_I:   hit = sync_i;
         TRIG_Q:   hit = sync_q;
         default:  hit = sync_i & sync_q;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/log_capture_sequencer_tick_down_counter.sv
// Loadable down-counter that decrements on enabled sample ticks.
// Ports:
//   clk, i_reset  : clock, synchronous active-high reset
//   i_load        : load i_load_val (wins over a decrement)
//   i_load_val    : value to load
//   i_en          : counting enabled
//   i_tick        : decrement strobe
//   o_expire_c    : combinational, high on the tick that takes the count to zero
module log_capture_sequencer_tick_down_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   input  logic         i_tick,
   output logic         o_expire_c
);

   logic [W-1:0] count_q;

   // Count register; never wraps below zero.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         count_q <= '0;
      end else if (i_load) begin
         count_q <= i_load_val;
      end else if (i_en && i_tick && (count_q != '0)) begin
         count_q <= count_q - W'(1);
      end
   end

   assign o_expire_c = i_en & i_tick & (count_q == W'(1));

endmodule

// File: rtl/log_capture_sequencer.sv
// Sequences one armed, triggered, fixed-length capture into the block-RAM logger.
// Ports:
//   clk, i_reset                 : clock, synchronous active-high reset
//   i_start, i_abort             : 1-cycle control pulses from reg_file
//   i_trig_mode                  : 00 immediate, 01 I, 10 Q, 11 I and Q
//   i_sync_done_I/Q              : sync-done levels from the QPSK branches
//   i_sample_tick                : sample-rate strobe
//   i_delay                      : post-trigger delay in ticks (0 selects N_DELAY)
//   i_timeout                    : arm timeout in clk cycles (0 waits forever)
//   o_en_write, o_wr_adrs        : RAM write strobe and address
//   o_busy, o_done, o_timeout    : status (done/timeout sticky until next start)
//   o_state                      : current state code
module log_capture_sequencer
   import log_capture_sequencer_pkg::*;
#(
   parameter int unsigned RAM_DEPTH = 32768,
   parameter int unsigned N_DELAY   = 500,
   parameter int unsigned NBT_DELAY = 16,
   parameter int unsigned NBT_TMO   = 32,
   localparam int unsigned ADDR_W   = $clog2(RAM_DEPTH)
) (
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic                 i_abort,
   input  logic [TRIG_W-1:0]    i_trig_mode,
   input  logic                 i_sync_done_I,
   input  logic                 i_sync_done_Q,
   input  logic                 i_sample_tick,
   input  logic [NBT_DELAY-1:0] i_delay,
   input  logic [NBT_TMO-1:0]   i_timeout,
   output logic                 o_en_write,
   output logic [ADDR_W-1:0]    o_wr_adrs,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_timeout,
   output logic [STATE_W-1:0]   o_state
);

   state_e              state_q, state_d;
   logic [TRIG_W-1:0]   mode_q, mode_d;
   logic [NBT_TMO-1:0]  tmo_lim_q, tmo_lim_d;
   logic [NBT_TMO-1:0]  tmo_cnt_q, tmo_cnt_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic [ADDR_W-1:0]   wr_adrs_q, wr_adrs_d;
   logic                en_write_q, en_write_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                timeout_q, timeout_d;

   logic                 trig_c;
   logic                 tmo_hit_c;
   logic                 last_write_c;
   logic                 dly_load_c;
   logic                 dly_en_c;
   logic                 dly_expire_c;
   logic [NBT_DELAY-1:0] dly_val_c;

   // Decision terms shared by next-state and output logic.
   assign trig_c       = trig_hit(mode_q, i_sync_done_I, i_sync_done_Q);
   assign tmo_hit_c    = (tmo_lim_q != '0) && (tmo_cnt_q == tmo_lim_q - NBT_TMO'(1));
   assign last_write_c = (idx_q == ADDR_W'(RAM_DEPTH - 1));
   assign dly_val_c    = (i_delay == '0) ? NBT_DELAY'(N_DELAY) : i_delay;
   assign dly_en_c     = (state_q == ST_DELAY);

   // Post-trigger delay in sample ticks.
   log_capture_sequencer_tick_down_counter #(
      .W (NBT_DELAY)
   ) u_delay (
      .clk        (clk),
      .i_reset    (i_reset),
      .i_load     (dly_load_c),
      .i_load_val (dly_val_c),
      .i_en       (dly_en_c),
      .i_tick     (i_sample_tick),
      .o_expire_c (dly_expire_c)
   );

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         mode_q     <= '0;
         tmo_lim_q  <= '0;
         tmo_cnt_q  <= '0;
         idx_q      <= '0;
         wr_adrs_q  <= '0;
         en_write_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         tmo_lim_q  <= tmo_lim_d;
         tmo_cnt_q  <= tmo_cnt_d;
         idx_q      <= idx_d;
         wr_adrs_q  <= wr_adrs_d;
         en_write_q <= en_write_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         timeout_q  <= timeout_d;
      end
   end

   // Next-state logic; abort beats every other event outside IDLE.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (i_start && !i_abort) state_d = ST_ARM;
         end
         ST_ARM: begin
            if (i_abort)        state_d = ST_IDLE;
            else if (trig_c)    state_d = ST_DELAY;
            else if (tmo_hit_c) state_d = ST_DONE;
         end
         ST_DELAY: begin
            if (i_abort)           state_d = ST_IDLE;
            else if (dly_expire_c) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (i_abort)                            state_d = ST_IDLE;
            else if (i_sample_tick && last_write_c) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (i_abort)      state_d = ST_IDLE;
            else if (i_start) state_d = ST_ARM;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the registered outputs and counters.
   always_comb begin
      mode_d     = mode_q;
      tmo_lim_d  = tmo_lim_q;
      tmo_cnt_d  = tmo_cnt_q;
      idx_d      = idx_q;
      wr_adrs_d  = wr_adrs_q;
      en_write_d = 1'b0;
      done_d     = done_q;
      timeout_d  = timeout_q;
      dly_load_c = 1'b0;
      busy_d     = (state_d == ST_ARM) || (state_d == ST_DELAY) || (state_d == ST_CAPTURE);

      unique case (state_q)
         ST_IDLE, ST_DONE: begin
            // A new capture clears status and latches its configuration.
            if (state_d == ST_ARM) begin
               mode_d    = i_trig_mode;
               tmo_lim_d = i_timeout;
               tmo_cnt_d = '0;
               idx_d     = '0;
               wr_adrs_d = '0;
               done_d    = 1'b0;
               timeout_d = 1'b0;
            end
         end
         ST_ARM: begin
            if (state_d == ST_DELAY) begin
               dly_load_c = 1'b1;
            end else if (state_d == ST_DONE) begin
               done_d    = 1'b1;
               timeout_d = 1'b1;
            end else if (state_d == ST_ARM) begin
               tmo_cnt_d = tmo_cnt_q + NBT_TMO'(1);
            end
         end
         ST_CAPTURE: begin
            // Write strobe follows its tick by one cycle; the last address is held.
            if (!i_abort && i_sample_tick) begin
               en_write_d = 1'b1;
               wr_adrs_d  = idx_q;
               if (last_write_c) done_d = 1'b1;
               else              idx_d  = idx_q + ADDR_W'(1);
            end
         end
         default: ;
      endcase
   end

   assign o_en_write = en_write_q;
   assign o_wr_adrs  = wr_adrs_q;
   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_timeout  = timeout_q;
   assign o_state    = state_q;

endmodule

// File: tb/tb_log_capture_sequencer.sv
// Self-checking bench for log_capture_sequencer (RAM_DEPTH=16, N_DELAY=4,
// sample tick every 3 clk). Expected outputs come from a tick-counting
// reference model of the capture rules.
module tb_log_capture_sequencer;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned ND    = 4;

   logic        clk = 1'b0;
   logic        i_reset, i_start, i_abort;
   logic [1:0]  i_trig_mode;
   logic        i_sync_done_I, i_sync_done_Q, i_sample_tick;
   logic [15:0] i_delay;
   logic [31:0] i_timeout;
   logic        o_en_write, o_busy, o_done, o_timeout;
   logic [3:0]  o_wr_adrs;
   logic [2:0]  o_state;

   always #5 clk = ~clk;

   log_capture_sequencer #(
      .RAM_DEPTH (DEPTH),
      .N_DELAY   (ND),
      .NBT_DELAY (16),
      .NBT_TMO   (32)
   ) dut (
      .clk           (clk),
      .i_reset       (i_reset),
      .i_start       (i_start),
      .i_abort       (i_abort),
      .i_trig_mode   (i_trig_mode),
      .i_sync_done_I (i_sync_done_I),
      .i_sync_done_Q (i_sync_done_Q),
      .i_sample_tick (i_sample_tick),
      .i_delay       (i_delay),
      .i_timeout     (i_timeout),
      .o_en_write    (o_en_write),
      .o_wr_adrs     (o_wr_adrs),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_timeout     (o_timeout),
      .o_state       (o_state)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: waiting for trigger, counting ticks after trigger, or finished.
   bit          m_armed, m_trig, m_fin, m_done, m_tmo, m_en;
   int          m_adrs, m_nt, m_dly, m_arm_cyc;
   logic [1:0]  m_mode;
   int unsigned m_tmo_lim;

   bit tick_en  = 1'b0;
   int tick_ph  = 0;
   int strobes  = 0;
   int busy_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_state();
      if (m_armed) return 1;
      if (m_trig)  return (m_nt < m_dly) ? 2 : 3;
      if (m_fin)   return 4;
      return 0;
   endfunction

   task automatic model_step();
      bit busy;
      bit hit;
      busy = m_armed || m_trig;
      m_en = 1'b0;
      if (i_reset) begin
         m_armed = 0; m_trig = 0; m_fin = 0; m_done = 0; m_tmo = 0; m_adrs = 0;
      end else if (i_abort && (m_armed || m_trig || m_fin)) begin
         m_armed = 0; m_trig = 0; m_fin = 0;
      end else if (!busy && i_start && !i_abort) begin
         m_armed = 1; m_fin = 0; m_done = 0; m_tmo = 0; m_adrs = 0; m_arm_cyc = 0;
         m_mode = i_trig_mode; m_tmo_lim = i_timeout;
      end else if (m_armed) begin
         case (m_mode)
            2'b00:   hit = 1'b1;
            2'b01:   hit = i_sync_done_I;
            2'b10:   hit = i_sync_done_Q;
            default: hit = i_sync_done_I && i_sync_done_Q;
         endcase
         if (hit) begin
            m_armed = 0; m_trig = 1; m_nt = 0;
            m_dly = (i_delay == 16'd0) ? int'(ND) : int'(i_delay);
         end else begin
            m_arm_cyc++;
            if (m_tmo_lim != 0 && m_arm_cyc == int'(m_tmo_lim)) begin
               m_armed = 0; m_fin = 1; m_done = 1; m_tmo = 1;
            end
         end
      end else if (m_trig && i_sample_tick) begin
         m_nt++;
         if (m_nt > m_dly) begin
            m_en   = 1'b1;
            m_adrs = m_nt - m_dly - 1;
            if (m_nt == m_dly + int'(DEPTH)) begin
               m_trig = 0; m_fin = 1; m_done = 1;
            end
         end
      end
   endtask

   // One clock: drive tick, advance model, then compare all outputs after the edge.
   task automatic cycle();
      i_sample_tick = tick_en && (tick_ph == 0);
      tick_ph = (tick_ph == 2) ? 0 : tick_ph + 1;
      model_step();
      @(posedge clk);
      #1;
      if (o_en_write === 1'b1) strobes++;
      if (o_busy === 1'b1) busy_cnt++;
      chk("en_write", 32'(o_en_write), 32'(m_en));
      chk("wr_adrs",  32'(o_wr_adrs),  32'(m_adrs));
      chk("busy",     32'(o_busy),     32'(m_armed || m_trig));
      chk("done",     32'(o_done),     32'(m_done));
      chk("timeout",  32'(o_timeout),  32'(m_tmo));
      chk("state",    32'(o_state),    32'(exp_state()));
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic pulse_start();
      i_start = 1'b1;
      cycle();
      i_start = 1'b0;
   endtask

   task automatic run_until_done(input int budget);
      int n = 0;
      while (o_done !== 1'b1 && n < budget) begin
         cycle();
         n++;
      end
      chk("done_wait", 32'(o_done), 32'd1);
   endtask

   task automatic run_until_write(input int a, input int budget);
      int n = 0;
      while (!(o_en_write === 1'b1 && o_wr_adrs == 4'(a)) && n < budget) begin
         cycle();
         n++;
      end
      chk("write_wait", {27'd0, o_en_write, o_wr_adrs}, 32'(16 + a));
   endtask

   initial begin
      int s0;
      i_reset = 1'b1; i_start = 1'b0; i_abort = 1'b0; i_trig_mode = 2'b00;
      i_sync_done_I = 1'b0; i_sync_done_Q = 1'b0; i_sample_tick = 1'b0;
      i_delay = 16'd0; i_timeout = 32'd0;

      // Reset state
      run(3);
      i_reset = 1'b0;
      tick_en = 1'b1;
      run(2);

      // Immediate capture with default delay
      strobes = 0;
      pulse_start();
      chk("imm_busy_next", 32'(o_busy), 32'd1);
      run_until_done(200);
      run(12);
      chk("imm_strobes", 32'(strobes), 32'(DEPTH));
      chk("imm_last_adrs", 32'(o_wr_adrs), 32'(DEPTH - 1));

      // Trigger on I and Q
      i_trig_mode = 2'b11; i_sync_done_I = 1'b1; i_sync_done_Q = 1'b0;
      strobes = 0;
      pulse_start();
      run(50);
      chk("trig_armed", 32'(o_state), 32'd1);
      chk("trig_no_strobe", 32'(strobes), 32'd0);
      i_sync_done_Q = 1'b1;
      cycle();
      chk("trig_delay", 32'(o_state), 32'd2);
      run_until_done(200);
      run(6);
      chk("trig_strobes", 32'(strobes), 32'(DEPTH));

      // Arm timeout
      i_trig_mode = 2'b01; i_sync_done_I = 1'b0; i_timeout = 32'd20;
      strobes = 0;
      busy_cnt = 0;
      pulse_start();
      run_until_done(100);
      run(4);
      chk("tmo_flag", 32'(o_timeout), 32'd1);
      chk("tmo_arm_cycles", 32'(busy_cnt), 32'd20);
      chk("tmo_strobes", 32'(strobes), 32'd0);

      // Abort at write index 7, then restart from address 0
      i_trig_mode = 2'b00; i_timeout = 32'd0;
      pulse_start();
      run_until_write(7, 200);
      i_abort = 1'b1;
      cycle();
      i_abort = 1'b0;
      chk("abort_idle", 32'(o_state), 32'd0);
      s0 = strobes;
      run(20);
      chk("abort_no_strobe", 32'(strobes - s0), 32'd0);
      chk("abort_done", 32'(o_done), 32'd0);
      pulse_start();
      run_until_write(0, 200);
      run_until_done(200);

      // Start with abort in IDLE stays IDLE
      i_abort = 1'b1;
      run(2);
      i_abort = 1'b0;
      run(2);
      i_start = 1'b1; i_abort = 1'b1;
      cycle();
      i_start = 1'b0; i_abort = 1'b0;
      chk("start_abort_idle", 32'(o_state), 32'd0);

      // Start during capture is ignored
      strobes = 0;
      pulse_start();
      run_until_write(3, 200);
      pulse_start();
      run_until_done(200);
      run(6);
      chk("restart_ignored_strobes", 32'(strobes), 32'(DEPTH));

      // Reset mid-capture, then a full restart
      pulse_start();
      run_until_write(5, 200);
      i_reset = 1'b1;
      cycle();
      i_reset = 1'b0;
      chk("reset_state", 32'(o_state), 32'd0);
      chk("reset_en", 32'(o_en_write), 32'd0);
      strobes = 0;
      pulse_start();
      run_until_done(200);
      chk("reset_restart_strobes", 32'(strobes), 32'(DEPTH));

      // Randomized traffic: config churn while busy, sync toggles, stray start/abort
      for (int it = 0; it < 8; it++) begin
         i_trig_mode   = 2'($urandom_range(0, 3));
         i_delay       = 16'($urandom_range(0, 6));
         i_timeout     = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'($urandom_range(5, 80));
         i_sync_done_I = 1'($urandom_range(0, 1));
         i_sync_done_Q = 1'($urandom_range(0, 1));
         tick_ph       = $urandom_range(0, 2);
         pulse_start();
         for (int c = 0; c < 250; c++) begin
            if ($urandom_range(0, 19) == 0) i_sync_done_I = ~i_sync_done_I;
            if ($urandom_range(0, 19) == 0) i_sync_done_Q = ~i_sync_done_Q;
            if ($urandom_range(0, 9) == 0) begin
               i_trig_mode = 2'($urandom_range(0, 3));
               i_delay     = 16'($urandom_range(0, 6));
               i_timeout   = 32'($urandom_range(0, 80));
            end
            i_abort = ($urandom_range(0, 299) == 0);
            i_start = ($urandom_range(0, 149) == 0);
            cycle();
            i_abort = 1'b0;
            i_start = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
